// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding, frame constants and instruction field positions
package program_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_e;
  localparam int HEADER_BYTES   = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CHK_BYTES      = 1;
  localparam int OPC_MSB  = 27;
  localparam int OPC_LSB  = 24;
  localparam int DST_MSB  = 23;
  localparam int DST_LSB  = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC0_MSB = 7;
  localparam int SRC0_LSB = 0;
endpackage

// File: rtl/instr_word_assembler.sv
// instr_word_assembler: shifts data bytes into an instruction word and keeps the running XOR checksum
module instr_word_assembler
  import program_loader_pkg::*;
#(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         accept_i,
  input  logic         is_data_i,
  input  logic [7:0]   byte_i,
  output logic [W-1:0] word_o,
  output logic         first_o,
  output logic         word_complete_o,
  output logic [7:0]   checksum_o
);
  logic [1:0]   idx_q;
  logic [W-1:0] word_q;
  logic [7:0]   chk_q;
  // byte0's upper nibble falls off the top of the W-bit register; it is required to be zero
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
      chk_q  <= '0;
    end else if (accept_i) begin
      chk_q <= chk_q ^ byte_i;
      if (is_data_i) begin
        word_q <= {word_q[W-9:0], byte_i};
        idx_q  <= idx_q + 2'd1;
      end
    end
  end
  assign word_o          = word_q;
  assign first_o         = idx_q == 2'd0;
  assign word_complete_o = accept_i && is_data_i && idx_q == 2'(BYTES_PER_WORD - 1);
  assign checksum_o      = chk_q;
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a framed byte stream into instruction RAM, holding the core in reset until verified
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 28,
  parameter int MAX_WORDS   = 256
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iStart,
  input  logic [7:0]             iByte,
  input  logic                   iByteValid,
  output logic                   oByteReady,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [INSTR_WIDTH-1:0] oWriteData,
  output logic                   oCoreReset,
  output logic                   oDone,
  output logic                   oError,
  output logic [15:0]            oWordCount
);
  state_e      state_q;
  logic [15:0] len_q, cnt_q, len_n;
  logic        ready_q, we_q, done_q, err_q, core_q;
  logic        fire, start, first, word_complete;
  logic [7:0]  checksum;
  assign fire  = iByteValid && ready_q;
  assign start = iStart && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign len_n = {len_q[15:8], iByte};
  instr_word_assembler #(.W(INSTR_WIDTH)) u_asm (
    .clk            (Clock),
    .rst            (Reset),
    .clear_i        (start),
    .accept_i       (fire && state_q != S_CHECK),
    .is_data_i      (state_q == S_DATA),
    .byte_i         (iByte),
    .word_o         (oWriteData),
    .first_o        (first),
    .word_complete_o(word_complete),
    .checksum_o     (checksum)
  );
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      core_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR:
          if (iStart) begin
            state_q <= S_LEN_HI;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            core_q  <= 1'b1;
          end
        S_LEN_HI:
          if (fire) begin
            len_q[15:8] <= iByte;
            state_q     <= S_LEN_LO;
          end
        S_LEN_LO:
          if (fire) begin
            len_q <= len_n;
            if ({16'd0, len_n} > 32'(MAX_WORDS)) begin
              state_q <= S_ERROR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end else state_q <= (len_n == 16'd0) ? S_CHECK : S_DATA;
          end
        S_DATA:
          if (fire) begin
            if (first && iByte[7:4] != 4'd0) begin
              state_q <= S_ERROR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end else if (word_complete) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
            end
          end
        S_WRITE: begin
          we_q    <= 1'b0;
          cnt_q   <= cnt_q + 16'd1;
          ready_q <= 1'b1;
          state_q <= (cnt_q + 16'd1 < len_q) ? S_DATA : S_CHECK;
        end
        S_CHECK:
          if (fire) begin
            ready_q <= 1'b0;
            state_q <= (iByte == checksum) ? S_DONE : S_ERROR;
            done_q  <= iByte == checksum;
            err_q   <= iByte != checksum;
            core_q  <= iByte != checksum;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign oByteReady    = ready_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = ADDR_WIDTH'(cnt_q);
  assign oCoreReset    = core_q;
  assign oDone         = done_q;
  assign oError        = err_q;
  assign oWordCount    = cnt_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random and directed frames checked against a frame-level reference model
module tb_program_loader;
  logic        Clock = 0, Reset = 1, iStart = 0, iByteValid = 0;
  logic [7:0]  iByte = 0;
  logic        oByteReady, oWriteEnable, oCoreReset, oDone, oError;
  logic [15:0] oWriteAddress, oWordCount;
  logic [27:0] oWriteData;
  int          checks = 0, errors = 0, n_cons;
  logic [7:0]  frame[$];
  logic [43:0] exp_w[$], got_w[$];
  bit          exp_done;

  program_loader dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iByte(iByte), .iByteValid(iByteValid),
    .oByteReady(oByteReady), .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress),
    .oWriteData(oWriteData), .oCoreReset(oCoreReset), .oDone(oDone), .oError(oError),
    .oWordCount(oWordCount)
  );

  always #5 Clock = ~Clock;
  always @(negedge Clock) if (oWriteEnable) got_w.push_back({oWriteAddress, oWriteData});

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // walks the frame the way the format defines it: what gets written, how many bytes are taken, pass/fail
  task automatic model();
    logic [7:0]  x, b;
    logic [31:0] wd;
    int          n;
    exp_w.delete();
    exp_done = 0;
    n = {16'd0, frame[0], frame[1]};
    x = frame[0] ^ frame[1];
    n_cons = 2;
    if (n > 256) return;
    for (int w = 0; w < n; w++) begin
      wd = 0;
      for (int k = 0; k < 4; k++) begin
        b = frame[2 + 4 * w + k];
        n_cons++;
        if (k == 0 && b[7:4] != 0) return;
        x ^= b;
        wd = {wd[23:0], b};
      end
      exp_w.push_back({16'(w), wd[27:0]});
    end
    n_cons++;
    exp_done = frame[2 + 4 * n] == x;
  endtask

  task automatic gen_frame(int n, int mode);
    logic [7:0] x = 0;
    int bad = $urandom_range(0, n - 1);
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    if (n > 256) return;
    for (int w = 0; w < n; w++) begin
      frame.push_back((mode == 1 && w == bad) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15)));
      repeat (3) frame.push_back(8'($urandom));
    end
    foreach (frame[i]) x ^= frame[i];
    frame.push_back(mode == 2 ? x ^ 8'($urandom_range(1, 255)) : x);
  endtask

  task automatic send_byte(logic [7:0] b);
    int t = 0;
    repeat ($urandom_range(0, 2)) @(negedge Clock);
    iByte = b;
    iByteValid = 1;
    while (!oByteReady && t < 40) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 40) check("ready_timeout", 0, 1);
    @(posedge Clock);
    #1;
    iByteValid = 0;
    iByte = 8'($urandom);
  endtask

  task automatic start_load();
    got_w.delete();
    @(negedge Clock);
    iStart = 1;
    @(negedge Clock);
    iStart = 0;
  endtask

  task automatic run_frame(string tag);
    int t = 0;
    model();
    start_load();
    for (int i = 0; i < n_cons; i++) send_byte(frame[i]);
    while (!(oDone || oError) && t < 20) begin
      @(negedge Clock);
      t++;
    end
    @(negedge Clock);
    check({tag, "_done"}, oDone, exp_done);
    check({tag, "_err"}, oError, !exp_done);
    check({tag, "_core"}, oCoreReset, !exp_done);
    check({tag, "_count"}, oWordCount, exp_w.size());
    check({tag, "_nwrites"}, got_w.size(), exp_w.size());
    foreach (exp_w[i]) check({tag, "_write"}, i < got_w.size() ? got_w[i] : '1, exp_w[i]);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_core"}, oCoreReset, 1);
    check({tag, "_flags"}, {oByteReady, oWriteEnable, oDone, oError}, 0);
    check({tag, "_addr"}, oWriteAddress, 0);
    check({tag, "_data"}, oWriteData, 0);
    check({tag, "_count"}, oWordCount, 0);
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    Reset = 0;
    @(negedge Clock);
    check_reset("reset");
    frame = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame("single");
    check("single_word", got_w.size() > 0 ? got_w[0] : '1, {16'h0, 28'h1020304});
    gen_frame(3, 0);
    run_frame("three");
    frame = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    run_frame("badchk");
    frame = '{8'h01, 8'h01};
    run_frame("toolong");
    gen_frame(2, 0);
    run_frame("recover1");
    frame = '{8'h00, 8'h01, 8'h10, 8'h02, 8'h03, 8'h04, 8'h00};
    run_frame("nibble");
    gen_frame(1, 0);
    run_frame("recover2");
    start_load();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge Clock);
    Reset = 1;
    @(negedge Clock);
    check_reset("midreset");
    check("midreset_nowrite", got_w.size(), 0);
    Reset = 0;
    gen_frame(2, 0);
    run_frame("afterreset");
    for (int r = 0; r < 12; r++) begin
      int mode = $urandom_range(0, 5);
      gen_frame(mode == 3 ? $urandom_range(257, 600) : $urandom_range(1, 6), mode);
      run_frame("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
